// File: rtl/de2_115_qsys_cpu_0_cpu_debug_action_sched_pkg.sv
// de2_115_qsys_cpu_0_cpu_debug_action_sched_pkg: shared op codes, FSM states, queue entry and defaults
package de2_115_qsys_cpu_0_cpu_debug_action_sched_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        OP_OCIMEM_A,
        OP_OCIMEM_B,
        OP_BREAK_A,
        OP_BREAK_B,
        OP_BREAK_C,
        OP_TRACECTRL
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] data;
        logic        rd;
    } action_t;

    // Strobe vector bit 0 is the highest priority (ocimem_a), bit 5 the lowest (tracectrl).
    function automatic action_t pick(input logic [5:0] s, input logic [31:0] data, input logic rd);
        action_t a;
        a.op   = s[0] ? OP_OCIMEM_A : s[1] ? OP_OCIMEM_B : s[2] ? OP_BREAK_A :
                 s[3] ? OP_BREAK_B  : s[4] ? OP_BREAK_C  : OP_TRACECTRL;
        a.data = data;
        a.rd   = rd;
        return a;
    endfunction

    function automatic logic [1:0] brk_index(input op_t op);
        return op == OP_BREAK_B ? 2'd1 : op == OP_BREAK_C ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/de2_115_qsys_cpu_0_cpu_debug_action_sched_if.sv
// de2_115_qsys_cpu_0_cpu_debug_action_sched_if: OCI memory bus between the scheduler (master) and memory (slave)
interface de2_115_qsys_cpu_0_cpu_debug_action_sched_if;

    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_waitrequest;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_waitrequest, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_waitrequest, mem_rdata
    );

endinterface

// File: rtl/de2_115_qsys_cpu_0_cpu_debug_action_fifo.sv
// de2_115_qsys_cpu_0_cpu_debug_action_fifo: synchronous action queue; a push while full is taken only if a pop frees the slot
module de2_115_qsys_cpu_0_cpu_debug_action_fifo
    import de2_115_qsys_cpu_0_cpu_debug_action_sched_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  action_t din,
    output action_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    action_t         mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            end
            if (do_pop)
                rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/de2_115_qsys_cpu_0_cpu_debug_action_sched.sv
// de2_115_qsys_cpu_0_cpu_debug_action_sched: queues JTAG debug actions and executes them one at a time
// against the OCI memory bus, break registers and trace control.
module de2_115_qsys_cpu_0_cpu_debug_action_sched
    import de2_115_qsys_cpu_0_cpu_debug_action_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_action_break_a,
    input  logic        take_action_break_b,
    input  logic        take_action_break_c,
    input  logic        take_action_tracectrl,
    de2_115_qsys_cpu_0_cpu_debug_action_sched_if.master bus,
    output logic        brk_write,
    output logic [1:0]  brk_sel,
    output logic [31:0] brk_wdata,
    output logic [1:0]  trc_ctrl,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    action_t       cur;
    action_t       head;
    logic [8:0]    addr;
    logic [31:0]   wdata;
    logic          rd_req;
    logic          wr_req;
    logic [TW-1:0] tcnt;
    logic [5:0]    strobes;
    logic          any;
    logic          multi;
    logic          pop;
    logic          empty;
    logic          drop;
    logic          clr_ovf;
    logic          unused_jdo;

    assign strobes = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                      take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
    assign any     = |strobes;
    assign multi   = |(strobes & (strobes - 6'd1));
    assign pop     = state == ST_IDLE && !empty;
    assign drop    = multi | (any & fifo_full & ~pop);
    assign clr_ovf = state == ST_ISSUE && cur.op == OP_OCIMEM_A;
    assign unused_jdo = ^jdo[36:32];

    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_read  = rd_req;
    assign bus.mem_write = wr_req;

    de2_115_qsys_cpu_0_cpu_debug_action_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (any),
        .pop     (pop),
        .din     (pick(strobes, jdo[31:0], jdo[37])),
        .dout    (head),
        .full    (fifo_full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cur           <= '0;
            addr          <= '0;
            wdata         <= '0;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            tcnt          <= '0;
            brk_write     <= 1'b0;
            brk_sel       <= '0;
            brk_wdata     <= '0;
            trc_ctrl      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            brk_write <= 1'b0;
            // A drop on the same edge as an ocimem_a execution wins: it is the newer event.
            overflow  <= drop | (overflow & ~clr_ovf);
            case (state)
                ST_IDLE: if (!empty) begin
                    cur   <= head;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_DONE;
                    case (cur.op)
                        OP_OCIMEM_A:  addr <= cur.data[8:0];
                        OP_OCIMEM_B: begin
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            rd_req        <= cur.rd;
                            wr_req        <= !cur.rd;
                            wdata         <= cur.data;
                            tcnt          <= '0;
                            state         <= ST_WAIT;
                        end
                        OP_TRACECTRL: trc_ctrl <= cur.data[1:0];
                        default: begin
                            brk_write <= 1'b1;
                            brk_sel   <= brk_index(cur.op);
                            brk_wdata <= cur.data;
                        end
                    endcase
                end
                ST_WAIT: if (!bus.mem_waitrequest || tcnt == TW'(TIMEOUT - 1)) begin
                    rd_req        <= 1'b0;
                    wr_req        <= 1'b0;
                    monitor_ready <= 1'b1;
                    state         <= ST_DONE;
                    if (!bus.mem_waitrequest) begin
                        if (rd_req)
                            MonDReg <= bus.mem_rdata;
                        addr <= addr + 9'd1;
                    end else begin
                        monitor_error <= 1'b1;
                    end
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_de2_115_qsys_cpu_0_cpu_debug_action_sched.sv
// tb_de2_115_qsys_cpu_0_cpu_debug_action_sched: directed scenarios plus randomized single actions
// checked against a transaction-level model of address, trace, overflow and read-data state.
module tb_de2_115_qsys_cpu_0_cpu_debug_action_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        oa = 1'b0, ob = 1'b0, ba = 1'b0, bb = 1'b0, bc = 1'b0, tc = 1'b0;
    logic        brk_write;
    logic [1:0]  brk_sel;
    logic [31:0] brk_wdata;
    logic [1:0]  trc_ctrl;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, fifo_full, overflow;
    logic [31:0] rdata_v = '0;
    int          wait_n = 0;
    int          stall_cnt = 0;
    int          total = 0, bad = 0;

    de2_115_qsys_cpu_0_cpu_debug_action_sched_if bus ();

    de2_115_qsys_cpu_0_cpu_debug_action_sched dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .jdo                   (jdo),
        .take_action_ocimem_a  (oa),
        .take_action_ocimem_b  (ob),
        .take_action_break_a   (ba),
        .take_action_break_b   (bb),
        .take_action_break_c   (bc),
        .take_action_tracectrl (tc),
        .bus                   (bus),
        .brk_write             (brk_write),
        .brk_sel               (brk_sel),
        .brk_wdata             (brk_wdata),
        .trc_ctrl              (trc_ctrl),
        .MonDReg               (MonDReg),
        .monitor_ready         (monitor_ready),
        .monitor_error         (monitor_error),
        .fifo_full             (fifo_full),
        .overflow              (overflow)
    );

    always #5 clk = ~clk;

    // Memory slave: stalls each request for wait_n cycles, then accepts it.
    always @(posedge clk) stall_cnt <= (bus.mem_read || bus.mem_write) ? stall_cnt + 1 : 0;
    assign bus.mem_waitrequest = (bus.mem_read || bus.mem_write) && (stall_cnt < wait_n);
    assign bus.mem_rdata       = rdata_v;

    int          brk_cnt = 0, req_len = 0, last_len = 0, stable_bad = 0, excl_bad = 0;
    logic [31:0] brk_log[$];
    logic [1:0]  last_sel = '0;
    logic [8:0]  r_addr = '0;
    logic        r_rd = 1'b0, req_q = 1'b0;
    logic [31:0] r_wd = '0;

    always @(negedge clk) begin
        logic req;
        req = bus.mem_read || bus.mem_write;
        if (brk_write) begin
            brk_cnt++;
            last_sel = brk_sel;
            brk_log.push_back(brk_wdata);
        end
        if (req && !req_q) begin
            r_addr  = bus.mem_addr;
            r_rd    = bus.mem_read;
            r_wd    = bus.mem_wdata;
            req_len = 0;
        end
        if (req) begin
            req_len++;
            if (bus.mem_addr != r_addr || bus.mem_read != r_rd || bus.mem_wdata != r_wd) stable_bad++;
        end
        if (!req && req_q) last_len = req_len;
        if (bus.mem_read && bus.mem_write) excl_bad++;
        req_q = req;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe bits: 0 ocimem_a, 1 ocimem_b, 2 break_a, 3 break_b, 4 break_c, 5 tracectrl.
    task automatic act(input logic [5:0] s, input logic [37:0] j);
        @(negedge clk);
        {tc, bc, bb, ba, ob, oa} = s;
        jdo = j;
        @(negedge clk);
        {tc, bc, bb, ba, ob, oa} = '0;
    endtask

    task automatic settle();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 16; i++) begin
            @(negedge clk);
            quiet = (bus.mem_read || bus.mem_write || brk_write) ? 0 : quiet + 1;
        end
        if (quiet < 16) chk("settle", 64'(quiet), 64'd16);
    endtask

    function automatic logic [37:0] mk(input logic rd, input logic [31:0] d);
        return {rd, 5'b0, d};
    endfunction

    logic [8:0]  m_addr;
    logic [1:0]  m_trc;
    logic        m_ov;
    logic [31:0] m_mon;

    initial begin
        int b0;
        repeat (2) @(negedge clk);
        chk("rst_rd", 64'(bus.mem_read), 64'd0);
        chk("rst_wr", 64'(bus.mem_write), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_outs", 64'({brk_write, brk_sel, brk_wdata, trc_ctrl, MonDReg}), 64'd0);
        chk("rst_flags", 64'({monitor_ready, monitor_error, fifo_full, overflow}), 64'b1000);
        reset_n = 1'b1;

        // Address load then a stalled read
        wait_n  = 3;
        rdata_v = 32'hDEADBEEF;
        act(6'b000001, mk(1'b0, 32'h010));
        settle();
        act(6'b000010, mk(1'b1, 32'h0));
        repeat (2) @(negedge clk);
        chk("lat_rd", 64'(bus.mem_read), 64'd1);
        chk("rd_addr", 64'(bus.mem_addr), 64'h010);
        settle();
        chk("rd_data", 64'(MonDReg), 64'hDEADBEEF);
        chk("rd_ready", 64'({monitor_ready, monitor_error}), 64'b10);
        chk("rd_inc", 64'(bus.mem_addr), 64'h011);
        chk("rd_len", 64'(last_len), 64'd4);

        // Address wrap on writes
        wait_n = 1;
        act(6'b000001, mk(1'b0, 32'h1FF));
        settle();
        act(6'b000010, mk(1'b0, 32'hA5A5_0001));
        settle();
        chk("wr1_addr", 64'(r_addr), 64'h1FF);
        chk("wr1_kind", 64'({r_rd, r_wd}), {1'b0, 32'hA5A5_0001});
        act(6'b000010, mk(1'b0, 32'h5A5A_0002));
        settle();
        chk("wr2_addr", 64'(r_addr), 64'h000);
        chk("wr2_inc", 64'(bus.mem_addr), 64'h001);
        chk("wr_mon", 64'(MonDReg), 64'hDEADBEEF);

        // Simultaneous break_b and tracectrl
        act(6'b100000, mk(1'b0, 32'h2));
        settle();
        chk("trc_set", 64'(trc_ctrl), 64'd2);
        b0 = brk_cnt;
        act(6'b101000, mk(1'b0, 32'h1234_5671));
        settle();
        chk("pri_cnt", 64'(brk_cnt - b0), 64'd1);
        chk("pri_sel", 64'(last_sel), 64'd1);
        chk("pri_data", 64'(brk_log[$]), 64'h1234_5671);
        chk("pri_trc", 64'(trc_ctrl), 64'd2);
        chk("pri_ovf", 64'(overflow), 64'd1);

        // Timeout
        wait_n = 1000;
        act(6'b000010, mk(1'b1, 32'h0));
        settle();
        chk("to_len", 64'(last_len), 64'd255);
        chk("to_flags", 64'({monitor_ready, monitor_error}), 64'b11);
        chk("to_addr", 64'(bus.mem_addr), 64'h001);
        chk("to_mon", 64'(MonDReg), 64'hDEADBEEF);
        chk("to_ovf", 64'(overflow), 64'd1);

        // Queue overflow while stalled
        act(6'b000001, mk(1'b0, 32'h0A0));
        settle();
        chk("ovf_clr", 64'(overflow), 64'd0);
        act(6'b000010, mk(1'b1, 32'h0));
        repeat (2) @(negedge clk);
        chk("q_stall", 64'(bus.mem_read), 64'd1);
        b0 = brk_cnt;
        for (int i = 0; i < 6; i++) begin
            ba  = 1'b1;
            jdo = mk(1'b0, 32'hB000_0000 + 32'(i));
            @(negedge clk);
        end
        ba = 1'b0;
        chk("q_full", 64'(fifo_full), 64'd1);
        chk("q_ovf", 64'(overflow), 64'd1);
        settle();
        chk("q_cnt", 64'(brk_cnt - b0), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("q_order", 64'(brk_log[b0 + i]), 64'hB000_0000 + 64'(i));
        chk("q_empty", 64'(fifo_full), 64'd0);

        // Reset in the middle of a stalled access
        act(6'b000010, mk(1'b1, 32'h0));
        repeat (2) @(negedge clk);
        chk("mr_req", 64'(bus.mem_read), 64'd1);
        act(6'b010000, mk(1'b0, 32'hC0));
        act(6'b010000, mk(1'b0, 32'hC1));
        b0 = brk_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mr_rd", 64'(bus.mem_read), 64'd0);
        chk("mr_flags", 64'({monitor_ready, fifo_full, overflow}), 64'b100);
        reset_n = 1'b1;
        settle();
        chk("mr_drop", 64'(brk_cnt - b0), 64'd0);

        // Randomized single actions, occasionally with a lower-priority collision
        m_addr = '0; m_trc = '0; m_ov = 1'b0; m_mon = '0;
        for (int it = 0; it < 40; it++) begin
            logic [5:0]  s;
            logic [37:0] j;
            int          pri;
            logic        multi;
            pri = $urandom_range(0, 5);
            s   = 6'b1 << pri;
            if ($urandom_range(0, 3) == 0) s[$urandom_range(pri, 5)] = 1'b1;
            multi   = $countones(s) > 1;
            j       = mk(1'($urandom_range(0, 1)), $urandom());
            wait_n  = $urandom_range(0, 5);
            rdata_v = $urandom();
            b0      = brk_cnt;
            act(s, j);
            repeat (2) @(negedge clk);
            if (pri == 1) begin
                chk("r_req", 64'({bus.mem_read, bus.mem_write}), j[37] ? 64'b10 : 64'b01);
                chk("r_addr", 64'(bus.mem_addr), 64'(m_addr));
            end else if (pri >= 2 && pri <= 4) begin
                chk("r_brk", 64'({brk_write, brk_sel, brk_wdata}), {1'b1, 2'(pri - 2), j[31:0]});
            end
            settle();
            if (pri == 0) m_addr = j[8:0];
            if (pri == 1) begin
                chk("r_len", 64'(last_len), 64'(wait_n + 1));
                if (!j[37]) chk("r_wd", 64'(r_wd), 64'(j[31:0]));
                if (j[37]) m_mon = rdata_v;
                m_addr = m_addr + 9'd1;
            end
            if (pri == 5) m_trc = j[1:0];
            m_ov = pri == 0 ? 1'b0 : (m_ov | multi);
            chk("r_cnt", 64'(brk_cnt - b0), (pri >= 2 && pri <= 4) ? 64'd1 : 64'd0);
            chk("r_state", {m_addr, m_trc, m_ov, m_mon}, 64'({bus.mem_addr, trc_ctrl, overflow, MonDReg}));
        end

        chk("stable", 64'(stable_bad), 64'd0);
        chk("excl", 64'(excl_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
